dds_ctrl_axil_regs: RTL and testbench
=====================================

// Module: dds_ctrl_axil_regs
// PURPOSE
// AXI4-Lite slave register file that is the control-plane end of the DDS controller.
// Four 32-bit R/W registers drive the DDS core: CTRL, PINC (phase increment), POFF (phase offset), SCRATCH.
// A phase accumulator produces the DDS phase word.
// Sits behind the AXI4-Lite master at the block-design boundary.
// PARAMETERS
// C_S_AXI_DATA_WIDTH  32  data bus width; only 32 supported
// C_S_AXI_ADDR_WIDTH  4   byte address width; decode uses addr[3:2]
// PHASE_WIDTH         32  accumulator / phase output width (<= 32)
// PORTS
// ACLK          in   1   clock; all logic rising-edge
// ARESETN       in   1   asynchronous active-low reset
// S_AXI_AWADDR  in   4   write address
// S_AXI_AWPROT  in   3   ignored
// S_AXI_AWVALID in   1   / S_AXI_AWREADY out 1  write-address handshake
// S_AXI_WDATA   in   32  write data
// S_AXI_WSTRB   in   4   byte enables
// S_AXI_WVALID  in   1   / S_AXI_WREADY  out 1  write-data handshake
// S_AXI_BRESP   out  2   always 2'b00 (OKAY)
// S_AXI_BVALID  out  1   / S_AXI_BREADY  in  1  write response
// S_AXI_ARADDR  in   4   read address
// S_AXI_ARPROT  in   3   ignored
// S_AXI_ARVALID in   1   / S_AXI_ARREADY out 1  read-address handshake
// S_AXI_RDATA   out  32  read data
// S_AXI_RRESP   out  2   always 2'b00
// S_AXI_RVALID  out  1   / S_AXI_RREADY  in  1  read data handshake
// dds_enable    out  1   CTRL[0]
// dds_pinc      out  PHASE_WIDTH  PINC[PHASE_WIDTH-1:0]
// dds_cfg_upd   out  1   one-cycle pulse after any commit to PINC or POFF
// dds_phase     out  PHASE_WIDTH  acc + POFF, registered
// BEHAVIOUR
// - Reset (async assert, sync release): all regs, acc, dds_phase = 0.
// - Reset also forces all READY/VALID outputs = 0 and RDATA = 0.
// - Map: 0x0 CTRL, 0x4 PINC, 0x8 POFF, 0xC SCRATCH. All 32 bits are stored and read back verbatim.
// - CTRL bit0 = enable. CTRL bit1 = phase clear (level).
// - Write channel:
//   - AWREADY and WREADY are independent. Each is high while its holding slot is empty and BVALID=0.
//   - AW and W may arrive in either order or in the same cycle; each is latched at its handshake.
//   - Commit: in the cycle after both slots are full, write the register (WSTRB per byte), raise BVALID and free both slots.
//   - BVALID is held until BREADY; no new AW/W is accepted while BVALID=1.
//   - Minimum latency: AW+W handshake at cycle N -> BVALID at N+1.
// - Read channel:
//   - ARREADY = !RVALID. RDATA is registered from the register array at the AR handshake; RVALID=1 next cycle.
//   - RVALID/RDATA are held stable until RREADY.
// - Read in the same cycle as a commit to the same address returns the pre-write value.
// - Read and write channels are fully concurrent.
// - Phase accumulator:
//   - Enabled and clear=0: acc <= acc + PINC, modulo 2^PHASE_WIDTH (wraps silently).
//   - clear=1: acc <= 0 (clear has priority over enable).
//   - enable=0: acc holds.
//   - dds_phase <= acc + POFF, modulo 2^PHASE_WIDTH, one cycle after acc.
// - Reset mid-transaction aborts everything: no B/R response is issued for in-flight transfers.
// TESTING
// - Write 1,2,3,4 to 0x0,0x4,0x8,0xC; read back in order -> RDATA 1,2,3,4, BRESP=RRESP=0.
// - W presented 3 cycles before AW at 0x8 (0xDEADBEEF) -> single BVALID after AW; readback 0xDEADBEEF.
// - PINC=0xFFFF_FFFF, CTRL=1 -> acc 0,FFFFFFFF,FFFFFFFE (wrap).
// - Above sequence with POFF=2 -> dds_phase=acc+2 one cycle later.
// - WSTRB=4'b0010, WDATA=0xAABBCCDD to SCRATCH=0x11223344 -> 0x1122CC44.
// - BREADY held low 10 cycles -> BVALID stays high; AWREADY/WREADY stay 0; release -> next write accepted.
// - ARESETN pulsed low during pending RVALID -> RVALID=0 immediately, registers read 0 afterwards.
// - CTRL=3 (enable+clear) -> acc stays 0; dds_cfg_upd pulses exactly once per PINC/POFF write.

Source files
------------

// File: rtl/dds_ctrl_axil_regs_if.sv
// rtl/dds_ctrl_axil_regs_if.sv - AXI4-Lite bus bundle between the block-design master and the DDS register file
interface dds_ctrl_axil_regs_if #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
);
   logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
   logic [2:0]                      S_AXI_AWPROT;
   logic                            S_AXI_AWVALID;
   logic                            S_AXI_AWREADY;
   logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
   logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
   logic                            S_AXI_WVALID;
   logic                            S_AXI_WREADY;
   logic [1:0]                      S_AXI_BRESP;
   logic                            S_AXI_BVALID;
   logic                            S_AXI_BREADY;
   logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
   logic [2:0]                      S_AXI_ARPROT;
   logic                            S_AXI_ARVALID;
   logic                            S_AXI_ARREADY;
   logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
   logic [1:0]                      S_AXI_RRESP;
   logic                            S_AXI_RVALID;
   logic                            S_AXI_RREADY;

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
      input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
      output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );
endinterface

// File: rtl/dds_ctrl_axil_regs.sv
// rtl/dds_ctrl_axil_regs.sv - AXI4-Lite CTRL/PINC/POFF/SCRATCH register file with DDS phase accumulator
module dds_ctrl_axil_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int PHASE_WIDTH        = 32
) (
   input  logic                   ACLK,
   input  logic                   ARESETN,
   dds_ctrl_axil_regs_if.slave    s_axi,
   output logic                   dds_enable,
   output logic [PHASE_WIDTH-1:0] dds_pinc,
   output logic                   dds_cfg_upd,
   output logic [PHASE_WIDTH-1:0] dds_phase
);
   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int NB = DW / 8;

   logic [DW-1:0]          regs [4];
   logic                   live;
   logic                   aw_full, w_full, bvalid, rvalid;
   logic [1:0]             aw_idx;
   logic [DW-1:0]          w_data;
   logic [NB-1:0]          w_strb;
   logic [DW-1:0]          rdata;
   logic [PHASE_WIDTH-1:0] acc;
   logic                   aw_hs, w_hs, ar_hs, commit;
   logic [1:0]             wr_idx;
   logic [DW-1:0]          wr_data, merged;
   logic [NB-1:0]          wr_strb;
   logic                   unused_bits;

   // live keeps every READY low until the first clock after reset release
   assign s_axi.S_AXI_AWREADY = live && !aw_full && !bvalid;
   assign s_axi.S_AXI_WREADY  = live && !w_full && !bvalid;
   assign s_axi.S_AXI_ARREADY = live && !rvalid;
   assign s_axi.S_AXI_BVALID  = bvalid;
   assign s_axi.S_AXI_BRESP   = 2'b00;
   assign s_axi.S_AXI_RVALID  = rvalid;
   assign s_axi.S_AXI_RDATA   = rdata;
   assign s_axi.S_AXI_RRESP   = 2'b00;

   assign aw_hs  = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
   assign w_hs   = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
   assign ar_hs  = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
   assign commit = (aw_full || aw_hs) && (w_full || w_hs);

   assign unused_bits = &{1'b0, s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                          s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

   // A slot filled this very cycle bypasses its holding register
   always_comb begin
      wr_idx  = aw_full ? aw_idx : s_axi.S_AXI_AWADDR[3:2];
      wr_data = w_full ? w_data : s_axi.S_AXI_WDATA;
      wr_strb = w_full ? w_strb : s_axi.S_AXI_WSTRB;
      merged  = regs[wr_idx];
      for (int b = 0; b < NB; b++) begin
         if (wr_strb[b]) merged[8*b +: 8] = wr_data[8*b +: 8];
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         live        <= 1'b0;
         aw_full     <= 1'b0;
         w_full      <= 1'b0;
         aw_idx      <= '0;
         w_data      <= '0;
         w_strb      <= '0;
         bvalid      <= 1'b0;
         dds_cfg_upd <= 1'b0;
      end else begin
         live        <= 1'b1;
         dds_cfg_upd <= commit && (wr_idx == 2'd1 || wr_idx == 2'd2);
         if (commit) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            bvalid  <= 1'b1;
         end else begin
            if (aw_hs) begin
               aw_full <= 1'b1;
               aw_idx  <= s_axi.S_AXI_AWADDR[3:2];
            end
            if (w_hs) begin
               w_full <= 1'b1;
               w_data <= s_axi.S_AXI_WDATA;
               w_strb <= s_axi.S_AXI_WSTRB;
            end
            if (bvalid && s_axi.S_AXI_BREADY) bvalid <= 1'b0;
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else if (commit) begin
         regs[wr_idx] <= merged;
      end
   end

   // Read samples the array before any same-edge commit lands
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rvalid <= 1'b0;
         rdata  <= '0;
      end else if (ar_hs) begin
         rvalid <= 1'b1;
         rdata  <= regs[s_axi.S_AXI_ARADDR[3:2]];
      end else if (rvalid && s_axi.S_AXI_RREADY) begin
         rvalid <= 1'b0;
      end
   end

   assign dds_enable = regs[0][0];
   assign dds_pinc   = regs[1][PHASE_WIDTH-1:0];

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         acc       <= '0;
         dds_phase <= '0;
      end else begin
         dds_phase <= acc + regs[2][PHASE_WIDTH-1:0];
         if (regs[0][1])      acc <= '0;
         else if (regs[0][0]) acc <= acc + dds_pinc;
      end
   end
endmodule

// File: tb/tb_dds_ctrl_axil_regs.sv
// tb/tb_dds_ctrl_axil_regs.sv - randomized self-checking bench for dds_ctrl_axil_regs against a behavioural model
`timescale 1ns/1ps
module tb_dds_ctrl_axil_regs;
   logic ACLK = 1'b0;
   logic ARESETN = 1'b0;
   always #5 ACLK = ~ACLK;

   dds_ctrl_axil_regs_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) bus ();

   logic        dds_enable, dds_cfg_upd;
   logic [31:0] dds_pinc, dds_phase;

   dds_ctrl_axil_regs #(
      .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .PHASE_WIDTH(32)
   ) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .s_axi(bus),
      .dds_enable(dds_enable), .dds_pinc(dds_pinc),
      .dds_cfg_upd(dds_cfg_upd), .dds_phase(dds_phase)
   );

   typedef struct {
      logic [1:0]  idx;
      logic [31:0] data;
      logic [3:0]  strb;
   } wr_t;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] m_regs [4];
   logic [31:0] m_acc, m_phase;
   wr_t         wq [$];
   bit          prev_b;
   int          upd_seen = 0;
   int          b_rises = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Model: register array plus acc/phase arithmetic, advanced once per clock
   initial begin
      wr_t   e;
      logic  exp_upd;
      forever begin
         @(posedge ACLK);
         #2;
         if (!ARESETN) begin
            for (int i = 0; i < 4; i++) m_regs[i] = '0;
            m_acc = '0; m_phase = '0; prev_b = 0;
            wq.delete();
            check1("rst_awready", bus.S_AXI_AWREADY, 1'b0);
            check1("rst_wready", bus.S_AXI_WREADY, 1'b0);
            check1("rst_arready", bus.S_AXI_ARREADY, 1'b0);
            check1("rst_bvalid", bus.S_AXI_BVALID, 1'b0);
            check1("rst_rvalid", bus.S_AXI_RVALID, 1'b0);
            check("rst_rdata", bus.S_AXI_RDATA, 32'h0);
            check("rst_phase", dds_phase, 32'h0);
         end else begin
            m_phase = m_acc + m_regs[2];
            if (m_regs[0][1])      m_acc = '0;
            else if (m_regs[0][0]) m_acc = m_acc + m_regs[1];
            exp_upd = 1'b0;
            if (bus.S_AXI_BVALID && !prev_b) begin
               b_rises++;
               if (wq.size() == 0) begin
                  check1("unexpected_bvalid", 1'b1, 1'b0);
               end else begin
                  e = wq.pop_front();
                  for (int b = 0; b < 4; b++)
                     if (e.strb[b]) m_regs[e.idx][8*b +: 8] = e.data[8*b +: 8];
                  exp_upd = (e.idx == 2'd1 || e.idx == 2'd2);
               end
            end
            prev_b = bus.S_AXI_BVALID;
            if (dds_cfg_upd) upd_seen++;
            check1("cfg_upd", dds_cfg_upd, exp_upd);
            check1("enable", dds_enable, m_regs[0][0]);
            check("pinc", dds_pinc, m_regs[1]);
            check("phase", dds_phase, m_phase);
            check("bresp", 32'(bus.S_AXI_BRESP), 32'h0);
            check("rresp", 32'(bus.S_AXI_RRESP), 32'h0);
         end
      end
   end

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly);
      wr_t e;
      int  n;
      e.idx = addr[3:2]; e.data = data; e.strb = strb;
      wq.push_back(e);
      fork
         begin
            int k = 0;
            repeat (aw_dly) @(negedge ACLK);
            bus.S_AXI_AWADDR = addr; bus.S_AXI_AWVALID = 1'b1;
            while (!bus.S_AXI_AWREADY && k < 200) begin @(negedge ACLK); k++; end
            if (k >= 200) check1("aw_timeout", 1'b1, 1'b0);
            @(negedge ACLK);
            bus.S_AXI_AWVALID = 1'b0;
         end
         begin
            int k = 0;
            repeat (w_dly) @(negedge ACLK);
            bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = strb; bus.S_AXI_WVALID = 1'b1;
            while (!bus.S_AXI_WREADY && k < 200) begin @(negedge ACLK); k++; end
            if (k >= 200) check1("w_timeout", 1'b1, 1'b0);
            @(negedge ACLK);
            bus.S_AXI_WVALID = 1'b0;
         end
      join
      n = 0;
      while (!bus.S_AXI_BVALID && n < 200) begin @(negedge ACLK); n++; end
      if (n >= 200) check1("b_timeout", 1'b1, 1'b0);
   endtask

   task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
      logic [31:0] exp;
      int          n = 0;
      bus.S_AXI_ARADDR = addr; bus.S_AXI_ARVALID = 1'b1;
      while (!bus.S_AXI_ARREADY && n < 200) begin @(negedge ACLK); n++; end
      if (n >= 200) check1("ar_timeout", 1'b1, 1'b0);
      exp = m_regs[addr[3:2]];
      @(negedge ACLK);
      bus.S_AXI_ARVALID = 1'b0;
      n = 0;
      while (!bus.S_AXI_RVALID && n < 200) begin @(negedge ACLK); n++; end
      if (n >= 200) check1("r_timeout", 1'b1, 1'b0);
      data = bus.S_AXI_RDATA;
      check("rd_model", data, exp);
      bus.S_AXI_RREADY = 1'b1;
      @(negedge ACLK);
      bus.S_AXI_RREADY = 1'b0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic [31:0] ph [4];
      wr_t         e;
      int          u0, b0, n;
      logic [31:0] pat0 [4];
      logic [31:0] pat2 [4];
      pat0[0] = 32'h0; pat0[1] = 32'h0; pat0[2] = 32'hFFFF_FFFF; pat0[3] = 32'hFFFF_FFFE;
      pat2[0] = 32'h2; pat2[1] = 32'h2; pat2[2] = 32'h1;         pat2[3] = 32'h0;

      bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
      bus.S_AXI_BREADY = 1'b1;
      bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
      bus.S_AXI_RREADY = 1'b0;
      ARESETN = 1'b0;
      repeat (3) @(negedge ACLK);
      ARESETN = 1'b1;
      repeat (2) @(negedge ACLK);

      for (int i = 0; i < 4; i++) axi_write(4'(4 * i), 32'(i + 1), 4'hF, 0, 0);
      for (int i = 0; i < 4; i++) begin
         axi_read(4'(4 * i), d);
         check("basic_readback", d, 32'(i + 1));
      end

      b0 = b_rises;
      axi_write(4'h8, 32'hDEAD_BEEF, 4'hF, 3, 0);
      repeat (3) @(negedge ACLK);
      check("w_first_single_b", 32'(b_rises - b0), 32'd1);
      axi_read(4'h8, d);
      check("w_first_readback", d, 32'hDEAD_BEEF);

      // Wrapping accumulator, first with POFF=0 then POFF=2
      axi_write(4'h0, 32'h2, 4'hF, 0, 0);
      axi_write(4'h4, 32'hFFFF_FFFF, 4'hF, 0, 0);
      axi_write(4'h8, 32'h0, 4'hF, 0, 0);
      axi_write(4'h0, 32'h1, 4'hF, 0, 0);
      for (int i = 0; i < 4; i++) begin
         ph[i] = dds_phase;
         @(negedge ACLK);
      end
      for (int i = 0; i < 4; i++) check("wrap_poff0", ph[i], pat0[i]);
      axi_write(4'h0, 32'h2, 4'hF, 0, 0);
      axi_write(4'h8, 32'h2, 4'hF, 0, 0);
      axi_write(4'h0, 32'h1, 4'hF, 0, 0);
      for (int i = 0; i < 4; i++) begin
         ph[i] = dds_phase;
         @(negedge ACLK);
      end
      for (int i = 0; i < 4; i++) check("wrap_poff2", ph[i], pat2[i]);

      axi_write(4'hC, 32'h1122_3344, 4'hF, 0, 0);
      axi_write(4'hC, 32'hAABB_CCDD, 4'b0010, 1, 0);
      axi_read(4'hC, d);
      check("wstrb_merge", d, 32'h1122_CC44);

      n = 0;
      while (!(bus.S_AXI_AWREADY && bus.S_AXI_WREADY) && n < 50) begin @(negedge ACLK); n++; end
      e.idx = 2'd3; e.data = 32'h5A5A_0001; e.strb = 4'hF;
      wq.push_back(e);
      bus.S_AXI_AWADDR = 4'hC; bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WDATA = 32'h5A5A_0001; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
      @(negedge ACLK);
      check1("min_latency_bvalid", bus.S_AXI_BVALID, 1'b1);
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
      @(negedge ACLK);

      bus.S_AXI_BREADY = 1'b0;
      axi_write(4'hC, 32'h0BAD_F00D, 4'hF, 0, 0);
      fork
         axi_write(4'hC, 32'h600D_CAFE, 4'hF, 0, 0);
         begin
            for (int i = 0; i < 10; i++) begin
               @(negedge ACLK);
               check1("bhold_bvalid", bus.S_AXI_BVALID, 1'b1);
               check1("bhold_awready", bus.S_AXI_AWREADY, 1'b0);
               check1("bhold_wready", bus.S_AXI_WREADY, 1'b0);
            end
            bus.S_AXI_BREADY = 1'b1;
         end
      join
      axi_read(4'hC, d);
      check("bhold_next_write", d, 32'h600D_CAFE);

      u0 = upd_seen;
      axi_write(4'h0, 32'h2, 4'hF, 0, 0);
      axi_write(4'h8, 32'h0, 4'hF, 2, 0);
      axi_write(4'h4, 32'h5, 4'hF, 0, 2);
      axi_write(4'hC, 32'h7, 4'hF, 0, 0);
      axi_write(4'h0, 32'h3, 4'hF, 0, 0);
      check("cfg_upd_count", 32'(upd_seen - u0), 32'd2);
      for (int i = 0; i < 5; i++) begin
         @(negedge ACLK);
         check("clear_priority", dds_phase, 32'h0);
      end

      for (int it = 0; it < 150; it++) begin
         int op;
         op = int'($urandom_range(0, 2));
         if (op == 0) begin
            axi_write(4'($urandom_range(0, 3) * 4), $urandom, 4'($urandom),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         end else if (op == 1) begin
            axi_read(4'($urandom_range(0, 3) * 4), d);
         end else begin
            fork
               axi_write(4'($urandom_range(0, 3) * 4), $urandom, 4'($urandom),
                         int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
               begin
                  logic [31:0] rd;
                  axi_read(4'($urandom_range(0, 3) * 4), rd);
               end
            join
         end
      end
      repeat (3) @(negedge ACLK);

      bus.S_AXI_RREADY = 1'b0;
      bus.S_AXI_ARADDR = 4'h4; bus.S_AXI_ARVALID = 1'b1;
      n = 0;
      while (!bus.S_AXI_ARREADY && n < 50) begin @(negedge ACLK); n++; end
      @(negedge ACLK);
      bus.S_AXI_ARVALID = 1'b0;
      n = 0;
      while (!bus.S_AXI_RVALID && n < 50) begin @(negedge ACLK); n++; end
      check1("pending_rvalid", bus.S_AXI_RVALID, 1'b1);
      ARESETN = 1'b0;
      #1;
      check1("async_rst_rvalid", bus.S_AXI_RVALID, 1'b0);
      check("async_rst_rdata", bus.S_AXI_RDATA, 32'h0);
      repeat (2) @(negedge ACLK);
      ARESETN = 1'b1;
      repeat (2) @(negedge ACLK);
      for (int i = 0; i < 4; i++) begin
         axi_read(4'(4 * i), d);
         check("post_rst_zero", d, 32'h0);
      end

      repeat (3) @(negedge ACLK);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
